npc_seq: RTL and testbench

- Parametrised next-PC sequencer for the microsequencer. Successor to the fixed 14-bit next-PC/PC register.
- Selects the next micro-PC from trap, SPC return, IR jump field, dispatch PC or incremented PC. Holds the current PC.
- Adds over the previous generation: fetch stall, latched pending trap, skip-next (PC+2), sticky wrap flag, trap-taken pulse, optional non-sequential-transfer history ring.
- Sits between the SPC stack, dispatch memory, IR and the control-memory address path.

---
 rtl/npc_seq_if.sv | 50 +++++
 rtl/npc_seq.sv | 162 ++++++++++++++++
 tb/tb_npc_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_seq_if.sv
// npc_seq_if: bundles the control, operand and status signals of the next-PC
// sequencer so the top module exposes one bus port beside clk/reset.
// The master side is the microsequencer control; the slave side is npc_seq.
// PC_W and HIST_DEPTH must match the parameters of the attached npc_seq.
interface npc_seq_if #(
  parameter int unsigned PC_W       = 14,
  parameter int unsigned HIST_DEPTH = 8
);
  localparam int unsigned HIDX_W = $clog2(HIST_DEPTH);
  localparam int unsigned CNT_W  = HIDX_W + 1;

  // fetch control
  logic              state_fetch;
  logic              stall;
  logic              trap;

  // next-PC source select and operands
  logic [1:0]        pcs;
  logic [PC_W-1:0]   spc;
  logic              spc1a;
  logic [PC_W-1:0]   ir_addr;
  logic [PC_W-1:0]   dpc;
  logic              skip;
  logic              clr_wrap;

  // PC and status
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   ipc;
  logic [PC_W-1:0]   npc;
  logic              trap_pend;
  logic              trap_taken;
  logic              wrap;

  // non-sequential transfer history
  logic [HIDX_W-1:0] hist_idx;
  logic [PC_W-1:0]   hist_pc;
  logic [CNT_W-1:0]  hist_count;

  modport master (
    output state_fetch, stall, trap, pcs, spc, spc1a, ir_addr, dpc, skip,
           clr_wrap, hist_idx,
    input  pc, ipc, npc, trap_pend, trap_taken, wrap, hist_pc, hist_count
  );

  modport slave (
    input  state_fetch, stall, trap, pcs, spc, spc1a, ir_addr, dpc, skip,
           clr_wrap, hist_idx,
    output pc, ipc, npc, trap_pend, trap_taken, wrap, hist_pc, hist_count
  );
endinterface

// File: rtl/npc_seq.sv
// npc_seq: next micro-PC sequencer. Picks the next PC from trap vector, SPC
// return, IR jump field, dispatch PC or the incremented PC, holds the current
// PC, latches traps that arrive while a fetch is stalled and tracks a sticky
// wrap flag for sequential overflow.
// Optional macro NPC_HIST_EN adds a ring of the PCs from which
// non-sequential transfers were taken; without it hist_pc/hist_count are 0.
module npc_seq #(
  parameter int unsigned     PC_W       = 14,
  parameter logic [PC_W-1:0] TRAP_VEC   = '0,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     HIST_DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  npc_seq_if.slave bus
);

  localparam int unsigned HIDX_W = $clog2(HIST_DEPTH);
  localparam int unsigned CNT_W  = HIDX_W + 1;
  localparam int unsigned SUM_W  = PC_W + 1;

  localparam logic [1:0] PCS_SPC = 2'b00;
  localparam logic [1:0] PCS_IR  = 2'b01;
  localparam logic [1:0] PCS_DPC = 2'b10;
  localparam logic [1:0] PCS_SEQ = 2'b11;

  logic [PC_W-1:0]  pc_q;
  logic             pend_q;
  logic             taken_q;
  logic             wrap_q;

  logic             accept;
  logic             trap_path;
  logic [PC_W-1:0]  ipc;
  logic [SUM_W-1:0] seq_sum;
  logic             seq_carry;
  logic [PC_W-1:0]  spc_ret;
  logic [PC_W-1:0]  npc;
  logic             wrap_set;

  // A fetch is accepted only when not stalled; a latched trap keeps forcing
  // the trap vector until some fetch is accepted.
  assign accept    = bus.state_fetch & ~bus.stall;
  assign trap_path = bus.trap | pend_q;

  // Incremented PC and the sequential sum with carry-out for wrap detection.
  assign ipc       = pc_q + PC_W'(1);
  assign seq_sum   = {1'b0, pc_q} + (bus.skip ? SUM_W'(2) : SUM_W'(1));
  assign seq_carry = seq_sum[PC_W];

  // SPC return address with bit 1 overridden by spc1a.
  always_comb begin
    spc_ret    = bus.spc;
    spc_ret[1] = bus.spc1a;
  end

  // Next-PC priority select: trap first, then the pcs-selected source.
  always_comb begin
    npc = seq_sum[PC_W-1:0];
    if (trap_path) begin
      npc = TRAP_VEC;
    end else begin
      unique case (bus.pcs)
        PCS_SPC: npc = spc_ret;
        PCS_IR:  npc = bus.ir_addr;
        PCS_DPC: npc = bus.dpc;
        PCS_SEQ: npc = seq_sum[PC_W-1:0];
        default: npc = seq_sum[PC_W-1:0];
      endcase
    end
  end

  // Wrap is only flagged by a real sequential advance, never by a trap.
  assign wrap_set = accept & (bus.pcs == PCS_SEQ) & ~trap_path & seq_carry;

  // Current PC register: loads the selected next PC on every accepted fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (accept) begin
      pc_q <= npc;
    end
  end

  // Trap bookkeeping: any accept consumes the trap; an unaccepted trap is
  // latched; trap_taken pulses for one cycle after a trap-vector load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      taken_q <= accept & trap_path;
      if (accept) begin
        pend_q <= 1'b0;
      end else if (bus.trap) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Sticky wrap flag; a set in the same cycle beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else if (wrap_set) begin
      wrap_q <= 1'b1;
    end else if (bus.clr_wrap) begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.ipc        = ipc;
  assign bus.npc        = npc;
  assign bus.trap_pend  = pend_q;
  assign bus.trap_taken = taken_q;
  assign bus.wrap       = wrap_q;

`ifdef NPC_HIST_EN
  logic [PC_W-1:0]   hist_mem [HIST_DEPTH];
  logic [HIDX_W-1:0] wr_ptr;
  logic [HIDX_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  hist_cnt;
  logic              hist_wr;

  // Any accepted transfer that is not a plain +1 step is recorded.
  assign hist_wr = accept & (npc != ipc);

  // Write pointer and saturating fill count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      hist_cnt <= '0;
    end else if (hist_wr) begin
      wr_ptr <= wr_ptr + HIDX_W'(1);
      if (hist_cnt != CNT_W'(HIST_DEPTH)) begin
        hist_cnt <= hist_cnt + CNT_W'(1);
      end
    end
  end

  // Ring storage holds the PC from which the transfer departed; not reset.
  always_ff @(posedge clk) begin
    if (hist_wr) begin
      hist_mem[wr_ptr] <= pc_q;
    end
  end

  // Index 0 reads the newest entry; the pointer arithmetic wraps naturally.
  assign rd_ptr         = wr_ptr - HIDX_W'(1) - bus.hist_idx;
  assign bus.hist_pc    = hist_mem[rd_ptr];
  assign bus.hist_count = hist_cnt;
`else
  logic unused_hist_idx;

  // History disabled: ports tied off, read index has no effect.
  assign unused_hist_idx = ^bus.hist_idx;
  assign bus.hist_pc     = '0;
  assign bus.hist_count  = '0;
`endif

endmodule

// File: tb/tb_npc_seq.sv
// tb_npc_seq: directed and randomized test of npc_seq against a behavioural
// model. Build with +define+NPC_HIST_EN to exercise the history ring.
`timescale 1ns/1ps
module tb_npc_seq;
  localparam int unsigned     PC_W     = 14;
  localparam int unsigned     HD       = 4;
  localparam int              M        = 1 << PC_W;
  localparam logic [PC_W-1:0] RESET_PC = 14'h0100;
  localparam logic [PC_W-1:0] TRAP_VEC = 14'h2A5A;
`ifdef NPC_HIST_EN
  localparam int              HIST_ON  = 1;
`else
  localparam int              HIST_ON  = 0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  bit   check_en;

  npc_seq_if #(.PC_W(PC_W), .HIST_DEPTH(HD)) bus ();

  npc_seq #(
    .PC_W(PC_W), .TRAP_VEC(TRAP_VEC), .RESET_PC(RESET_PC), .HIST_DEPTH(HD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int m_pc;
  bit m_pend;
  bit m_taken;
  bit m_wrap;
  int hist_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected next PC straight from the priority rules, in plain integers.
  function automatic int model_npc();
    int v;
    if (bus.trap || m_pend) v = int'(TRAP_VEC);
    else begin
      case (bus.pcs)
        2'd0:    v = (int'(bus.spc) & ~2) + (bus.spc1a ? 2 : 0);
        2'd1:    v = int'(bus.ir_addr);
        2'd2:    v = int'(bus.dpc);
        default: v = (m_pc + (bus.skip ? 2 : 1)) % M;
      endcase
    end
    return v;
  endfunction

  // Model update on each edge, mirroring the architectural effect of a cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc    <= int'(RESET_PC);
      m_pend  <= 1'b0;
      m_taken <= 1'b0;
      m_wrap  <= 1'b0;
      hist_q.delete();
    end else begin
      bit acc;
      bit tp;
      bit wset;
      int n;
      acc  = bus.state_fetch && !bus.stall;
      tp   = bus.trap || m_pend;
      n    = model_npc();
      wset = acc && bus.pcs == 2'd3 && !tp && (m_pc + (bus.skip ? 2 : 1) >= M);
      if (acc) begin
        if (n != (m_pc + 1) % M) begin
          hist_q.push_front(m_pc);
          if (hist_q.size() > HD) void'(hist_q.pop_back());
        end
        m_pc   <= n;
        m_pend <= 1'b0;
      end else if (bus.trap) begin
        m_pend <= 1'b1;
      end
      m_taken <= acc && tp;
      if (wset) m_wrap <= 1'b1;
      else if (bus.clr_wrap) m_wrap <= 1'b0;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (check_en && !reset) begin
      chk("pc", int'(bus.pc), m_pc);
      chk("ipc", int'(bus.ipc), (m_pc + 1) % M);
      chk("npc", int'(bus.npc), model_npc());
      chk("trap_pend", int'(bus.trap_pend), int'(m_pend));
      chk("trap_taken", int'(bus.trap_taken), int'(m_taken));
      chk("wrap", int'(bus.wrap), int'(m_wrap));
`ifdef NPC_HIST_EN
      chk("hist_count", int'(bus.hist_count), hist_q.size());
      if (int'(bus.hist_idx) < hist_q.size())
        chk("hist_pc", int'(bus.hist_pc), hist_q[int'(bus.hist_idx)]);
`else
      chk("hist_count_off", int'(bus.hist_count), 0);
      chk("hist_pc_off", int'(bus.hist_pc), 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit f, input bit s, input bit t, input logic [1:0] p,
                       input bit sk, input bit cw);
    bus.state_fetch = f;
    bus.stall       = s;
    bus.trap        = t;
    bus.pcs         = p;
    bus.skip        = sk;
    bus.clr_wrap    = cw;
  endtask

  task automatic jump(input logic [PC_W-1:0] a);
    drive(1, 0, 0, 2'd1, 0, 0);
    bus.ir_addr = a;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    check_en = 1'b0;
    reset    = 1'b0;
    drive(0, 0, 0, 2'd3, 0, 0);
    bus.spc      = '0;
    bus.spc1a    = 1'b0;
    bus.ir_addr  = '0;
    bus.dpc      = '0;
    bus.hist_idx = '0;
    #2 reset = 1'b1;
    #1;
    chk("reset_pc", int'(bus.pc), 'h0100);
    chk("reset_pend", int'(bus.trap_pend), 0);
    chk("reset_wrap", int'(bus.wrap), 0);
    chk("reset_hist_count", int'(bus.hist_count), 0);
    tick();
    reset    = 1'b0;
    check_en = 1'b1;

    // Sequential advance from the reset PC
    drive(1, 0, 0, 2'd3, 0, 0);
    tick(); chk("seq1", int'(bus.pc), 'h0101);
    tick(); chk("seq2", int'(bus.pc), 'h0102);
    tick(); chk("seq3", int'(bus.pc), 'h0103);
    chk("seq3_ipc", int'(bus.ipc), 'h0104);

    // Wrap past all-ones, clear, wrap again via skip
    jump(14'h3FFF);
    drive(1, 0, 0, 2'd3, 0, 0);
    tick();
    chk("wrap_pc", int'(bus.pc), 0);
    chk("wrap_set", int'(bus.wrap), 1);
    drive(0, 0, 0, 2'd3, 0, 1);
    tick();
    chk("wrap_clr", int'(bus.wrap), 0);
    jump(14'h3FFE);
    drive(1, 0, 0, 2'd3, 1, 0);
    tick();
    chk("skip_wrap_pc", int'(bus.pc), 0);
    chk("skip_wrap", int'(bus.wrap), 1);

    // Source selection
    drive(1, 0, 0, 2'd0, 0, 0);
    bus.spc = 14'h1234; bus.spc1a = 1'b1;
    tick(); chk("spc_sel", int'(bus.pc), 'h1236);
    jump(14'h0ABC);
    chk("ir_sel", int'(bus.pc), 'h0ABC);
    drive(1, 0, 0, 2'd2, 0, 0);
    bus.dpc = 14'h2001;
    tick(); chk("dpc_sel", int'(bus.pc), 'h2001);

    // Trap latched during stall, taken on the next accept
    drive(1, 1, 1, 2'd3, 0, 0);
    tick();
    chk("stall_pend", int'(bus.trap_pend), 1);
    chk("stall_hold", int'(bus.pc), 'h2001);
    drive(1, 0, 0, 2'd3, 0, 0);
    tick();
    chk("trap_pc", int'(bus.pc), int'(TRAP_VEC));
    chk("trap_pend_clr", int'(bus.trap_pend), 0);
    chk("trap_taken", int'(bus.trap_taken), 1);
    drive(0, 0, 0, 2'd3, 0, 0);
    tick();
    chk("trap_taken_end", int'(bus.trap_taken), 0);

    // Async reset while a trap is pending
    drive(1, 1, 1, 2'd3, 0, 0);
    tick();
    chk("pend_before_rst", int'(bus.trap_pend), 1);
    reset = 1'b1;
    #1;
    chk("rst_pc", int'(bus.pc), 'h0100);
    chk("rst_pend", int'(bus.trap_pend), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    chk("rst_taken", int'(bus.trap_taken), 0);
    drive(0, 0, 0, 2'd3, 0, 0);
    #1 reset = 1'b0;
    tick();

    // History: six jumps departing from 0x10..0x60
    jump(14'h0010);
    for (int k = 2; k <= 7; k++) jump(PC_W'(k * 16));
    chk("hist_full", int'(bus.hist_count), HIST_ON * 4);
    for (int k = 0; k < 4; k++) begin
      bus.hist_idx = 2'(k);
      #1;
      chk("hist_entry", int'(bus.hist_pc), HIST_ON * (16 * (6 - k)));
    end
    drive(1, 0, 0, 2'd3, 0, 0);
    tick(); tick();
    bus.hist_idx = '0;
    #1;
    chk("hist_seq_count", int'(bus.hist_count), HIST_ON * 4);
    chk("hist_seq_top", int'(bus.hist_pc), HIST_ON * 'h60);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'b0);
      if (!bus.stall) bus.clr_wrap = ($urandom_range(0, 15) == 0);
      bus.spc      = PC_W'($urandom);
      bus.spc1a    = 1'($urandom_range(0, 1));
      bus.ir_addr  = ($urandom_range(0, 3) == 0) ? PC_W'(M - 1 - $urandom_range(0, 1))
                                                 : PC_W'($urandom);
      bus.dpc      = PC_W'($urandom);
      bus.hist_idx = 2'($urandom_range(0, HD - 1));
      tick();
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
